// File: rtl/cpu_run_control.sv
// CPU run control: turns the prescaler tick into a gated CPU clock-enable
// driven by a debounced run switch, a single-step button and the CPU halt request.
module cpu_run_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd50000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn_n,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t cur_state;
  state_t next_state;

  logic [1:0]      run_sync;
  logic [1:0]      step_sync;
  logic            run_synced;
  logic            step_synced;
  logic [DB_W-1:0] run_cnt;
  logic [DB_W-1:0] step_cnt;
  logic            run_db;
  logic            step_db;
  logic            step_prev;
  logic            step_press;
  logic            ce_next;

  // The button is active-low on the board; invert before synchronising so
  // everything downstream treats 1 as pressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_sync  <= 2'b00;
      step_sync <= 2'b00;
    end else begin
      run_sync  <= {run_sync[0], run_sw};
      step_sync <= {step_sync[0], ~step_btn_n};
    end
  end

  assign run_synced  = run_sync[1];
  assign step_synced = step_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt <= '0;
      run_db  <= 1'b0;
    end else if (run_synced == run_db) begin
      run_cnt <= '0;
    end else if (run_cnt == DB_MAX) begin
      run_db  <= run_synced;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      step_db  <= 1'b0;
    end else if (step_synced == step_db) begin
      step_cnt <= '0;
    end else if (step_cnt == DB_MAX) begin
      step_db  <= step_synced;
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_prev <= 1'b0;
    end else begin
      step_prev <= step_db;
    end
  end

  assign step_press = step_db & ~step_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Halt outranks the run switch in RUN; once HALTED only dropping run
  // returns to IDLE, so releasing halt_req alone never restarts the CPU.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (run_db) begin
          next_state = RUN;
        end else if (step_press) begin
          next_state = STEP;
        end
      end
      RUN: begin
        if (halt_req) begin
          next_state = HALTED;
        end else if (!run_db) begin
          next_state = IDLE;
        end
      end
      STEP: begin
        if (tick) begin
          next_state = halt_req ? HALTED : IDLE;
        end
      end
      HALTED: begin
        if (!run_db) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Enable is decided from the old state, so a tick on the edge that leaves
  // RUN or STEP still produces its pulse.
  assign ce_next = tick & ~halt_req & ((cur_state == RUN) | (cur_state == STEP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_ce <= ce_next;
      if (cpu_ce) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_cpu_run_control.sv
// Scoreboard bench for cpu_run_control: ticks are issued by the stimulus,
// expected enables are queued and a monitor checks each cpu_ce pulse.
module tb_cpu_run_control;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       run_sw;
  logic       step_btn_n;
  logic       halt_req;
  logic       cpu_ce;
  logic [1:0] state;
  logic [3:0] cycle_cnt;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;

  cpu_run_control #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .run_sw(run_sw),
    .step_btn_n(step_btn_n),
    .halt_req(halt_req),
    .cpu_ce(cpu_ce),
    .state(state),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every enable pulse must match the oldest queued expectation in both
  // timing and the counter value it sees.
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_ce: cpu_ce=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc) begin
          bad++;
          $display("[TB] FAIL ce_timing: pulse at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
        end
        total++;
        if (int'(cycle_cnt) != mon_e.cnt) begin
          bad++;
          $display("[TB] FAIL ce_count: cycle_cnt=%0d, expected %0d", cycle_cnt, mon_e.cnt);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One prescaler period: seven quiet cycles then a one-cycle tick.
  task automatic applyStimulus(input bit expect_ce, input bit with_halt);
    repeat (7) @(negedge clk);
    tick = 1'b1;
    if (with_halt) halt_req = 1'b1;
    if (expect_ce) begin
      sb.push_back('{cyc + 1, model_cnt});
      model_cnt = (model_cnt + 1) % 16;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    tick       = 1'b0;
    run_sw     = 1'b0;
    step_btn_n = 1'b1;
    halt_req   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_ce", int'(cpu_ce), 0);
    checkOutput("rst_cnt", int'(cycle_cnt), 0);
    rst_n = 1'b1;

    repeat (12) applyStimulus(1'b0, 1'b0);
    checkOutput("idle_state", int'(state), 0);
    checkOutput("idle_cnt", int'(cycle_cnt), 0);

    run_sw = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("run_pre_state", int'(state), 0);
    @(negedge clk);
    checkOutput("run_state", int'(state), 1);
    repeat (10) applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("run_cnt", int'(cycle_cnt), 10);
    run_sw = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("stop_state", int'(state), 0);

    step_btn_n = 1'b0;
    repeat (20) @(negedge clk);
    step_btn_n = 1'b1;
    checkOutput("step_state", int'(state), 2);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("step_done_state", int'(state), 0);
    checkOutput("step_cnt", int'(cycle_cnt), 11);

    step_btn_n = 1'b0;
    repeat (3) @(negedge clk);
    step_btn_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("glitch_state", int'(state), 0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("glitch_cnt", int'(cycle_cnt), 11);

    run_sw = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("halt_run_state", int'(state), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("halt_state", int'(state), 3);
    step_btn_n = 1'b0;
    repeat (10) @(negedge clk);
    step_btn_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("halt_step_state", int'(state), 3);
    halt_req = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("halt_rel_state", int'(state), 3);
    run_sw = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("halt_pre_exit", int'(state), 3);
    @(negedge clk);
    checkOutput("halt_exit", int'(state), 0);
    checkOutput("halt_cnt", int'(cycle_cnt), 11);

    run_sw = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("wrap_run_state", int'(state), 1);
    repeat (6) applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wrap_cnt", int'(cycle_cnt), 1);
    run_sw = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("wrap_idle_state", int'(state), 0);

    step_btn_n = 1'b0;
    repeat (20) @(negedge clk);
    step_btn_n = 1'b1;
    checkOutput("rst_step_state", int'(state), 2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rs_state", int'(state), 0);
    checkOutput("rs_ce", int'(cpu_ce), 0);
    checkOutput("rs_cnt", int'(cycle_cnt), 0);
    model_cnt = 0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_state", int'(state), 0);
    checkOutput("post_rst_cnt", int'(cycle_cnt), 0);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_control.md
Name: cpu_run_control

Overview:
- Sits directly downstream of the clock prescaler, in the main clk domain.
- Turns the prescaler's one-cycle tick into a gated CPU clock-enable, cpu_ce.
- Gating is set by a run switch, a single-step push button and the CPU's halt request.
- Also debounces the board switch/button and keeps a count of issued CPU cycles for SignalTap/LED debug.

Parameters:
- DEBOUNCE_CYCLES, 32'd50000: number of consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips. Minimum 2.
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk, input, 1: system clock. All logic is on posedge clk.
- rst_n, input, 1: synchronous, active-low reset.
- tick, input, 1: one-clk-cycle pulse from the prescaler, one per CPU period.
- run_sw, input, 1: raw board switch, asynchronous. 1 = free-run.
- step_btn_n, input, 1: raw push button, asynchronous, active-low.
- halt_req, input, 1: from the CPU, level. 1 = HLT executed.
- cpu_ce, output, 1: registered one-cycle clock-enable to the CPU.
- state, output, 2: FSM state encoding, for debug.
- cycle_cnt, output, CNT_W: count of cpu_ce pulses issued.

Behaviour:

Reset (rst_n=0 at a posedge clk):
- state=IDLE (2'd0), cpu_ce=0, cycle_cnt=0.
- Synchroniser flops = 0; debounce counters = 0.
- Stable run value = 0; stable step value = 0 (not pressed).
- Reset mid-operation aborts a pending step and drops cpu_ce on the next edge.

Input conditioning:
- run_sw and the inverted step_btn_n each pass through a 2-FF synchroniser.
- Each has its own debounce counter:
  - If synced == stable, counter = 0.
  - Otherwise counter increments.
  - When counter == DEBOUNCE_CYCLES-1 while synced != stable, stable <= synced and counter <= 0.
- Net effect: a clean raw change appears on the stable value DEBOUNCE_CYCLES+2 clk edges after the raw edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
- step_press = one-cycle pulse on the 0->1 transition of stable step (registered edge detect, 1 cycle after stable changes).

FSM (one transition per clk):
- IDLE (0)
  - run_db=1 -> RUN.
  - Else step_press -> STEP.
  - Else stay.
- RUN (1)
  - halt_req=1 -> HALTED. Highest priority.
  - Else run_db=0 -> IDLE.
  - Else stay.
  - step_press is ignored.
- STEP (2)
  - Waits for tick.
  - On tick with halt_req=0: issue one ce, then -> IDLE.
  - On tick with halt_req=1: no ce, -> HALTED.
  - run_db rising while in STEP is ignored until back in IDLE.
- HALTED (3)
  - cpu_ce=0.
  - run_db=0 -> IDLE.
  - step_press is ignored.
  - halt_req deasserting alone does not leave HALTED.

cpu_ce (registered):
- cpu_ce <= tick & ~halt_req & (state==RUN | state==STEP).
- Uses the current state, so there is exactly 1 clk of latency from tick.
- Never high on two consecutive cycles (tick is a pulse).
- A tick arriving on the same cycle that RUN exits to IDLE (run_db=0) still issues ce. State exit and ce evaluate on the same edge from the old state.

cycle_cnt:
- Increments by 1 on each cycle cpu_ce=1.
- Wraps modulo 2^CNT_W with no saturation and no flag.

Test Plan (DEBOUNCE_CYCLES=4; tick every 8 clk):
- Reset hold 3 cycles, then release, inputs idle (run_sw=0, step_btn_n=1) -> state=0, cpu_ce=0, cycle_cnt=0 for 100 cycles regardless of tick.
- run_sw 0->1 and hold -> state=1 at raw+7 edges (6 to stable, 1 to FSM). cpu_ce exactly 1 clk after each later tick. After 10 ticks, cycle_cnt=10.
- From IDLE: step_btn_n low for 20 cycles, then high -> exactly one cpu_ce, at tick+1. state returns to 0; cycle_cnt +1. A 3-cycle low glitch produces no ce.
- In RUN, assert halt_req on the same cycle as tick -> no cpu_ce, state=3. Step presses and halt_req release leave state=3. run_sw->0 -> state=0 after debounce.
- Force cycle_cnt near wrap (CNT_W=4, 15 pulses then one more) -> cycle_cnt 15->0 with no other effect.
- Assert rst_n=0 while in STEP awaiting tick -> next edge state=0, cpu_ce=0, cycle_cnt=0. A subsequent tick produces no ce.
